// File: rtl/systolic_pe_acc.sv
// Systolic-array processing element: forwards operands east/south and accumulates K-long
// dot-product tiles. Defining SYSTOLIC_PE_SAT_EN makes each accumulate step saturate instead of wrap.
module systolic_pe_acc #(
  parameter int ROW    = 0,
  parameter int COL    = 0,
  parameter int DW     = 8,
  parameter int AW     = 2*DW+8,
  parameter int K      = 8,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic          out_valid,
  output logic [AW-1:0] result,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          busy
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t          state, next_state;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] prod;
  logic [AW-1:0]   prod_ext;
  logic [AW-1:0]   step_base;
  logic [AW-1:0]   next_sum;
  logic [CW-1:0]   cnt_base;
  logic            tile_open;
  logic            take;
  logic            last;

  generate
    if (SIGNED != 0) begin : g_signed
      assign prod     = (2*DW)'($signed(in_a)) * (2*DW)'($signed(in_b));
      assign prod_ext = AW'($signed(prod));
    end else begin : g_unsigned
      assign prod     = (2*DW)'(in_a) * (2*DW)'(in_b);
      assign prod_ext = AW'(prod);
    end
  endgenerate

  // A start is honoured everywhere except in DONE while the result is still unaccepted.
  assign tile_open = start && ((state != DONE) || result_ready);
  assign take      = in_valid && (tile_open || (state == ACC));
  assign cnt_base  = tile_open ? '0 : cnt;
  assign step_base = tile_open ? '0 : acc;
  assign last      = take && (cnt_base == CW'(K-1));
  assign busy      = (state != IDLE);

`ifdef SYSTOLIC_PE_SAT_EN
  logic [AW:0] sum_full;

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    sum_full = {1'b0, step_base} + {1'b0, prod_ext};
    next_sum = sum_full[AW-1:0];
    if (SIGNED != 0) begin
      if ((step_base[AW-1] == prod_ext[AW-1]) && (next_sum[AW-1] != step_base[AW-1]))
        next_sum = step_base[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else if (sum_full[AW]) begin
      next_sum = '1;
    end
  end
`else
  assign next_sum = step_base + prod_ext;
`endif

  always_comb begin
    next_state = state;
    if (tile_open) begin
      next_state = last ? DONE : ACC;
    end else begin
      case (state)
        ACC:     if (last) next_state = DONE;
        DONE:    if (result_ready) next_state = IDLE;
        default: next_state = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_a        <= '0;
      out_b        <= '0;
      out_valid    <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_a <= in_a;
        out_b <= in_b;
      end

      // Release comes first so a back-to-back K=1 tile can re-assert result_valid below.
      if ((state == DONE) && result_ready)
        result_valid <= 1'b0;

      if (take) begin
        if (last) begin
          result       <= next_sum;
          result_valid <= 1'b1;
        end else begin
          acc <= next_sum;
          cnt <= cnt_base + CW'(1);
        end
      end else if (tile_open) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Self-checking bench: three PE configurations share one random/directed stimulus stream
// and are compared every cycle against a per-instance arithmetic reference model.
module tb_systolic_pe_acc;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, result_ready;
  logic [7:0] in_a, in_b;

  logic [7:0]  oa0, ob0, oa1, ob1, oa2, ob2;
  logic        ov0, ov1, ov2, rv0, rv1, rv2, bz0, bz1, bz2;
  logic [23:0] res0, res1;
  logic [15:0] res2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // 0: unsigned K=4 AW=24; 1: signed K=2 AW=24; 2: unsigned K=2 AW=16
  systolic_pe_acc #(.ROW(0), .COL(0), .DW(8), .K(4), .SIGNED(0)) u_main (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .out_a(oa0), .out_b(ob0), .out_valid(ov0), .result(res0), .result_valid(rv0),
    .result_ready(result_ready), .busy(bz0));

  systolic_pe_acc #(.ROW(0), .COL(1), .DW(8), .K(2), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .out_a(oa1), .out_b(ob1), .out_valid(ov1), .result(res1), .result_valid(rv1),
    .result_ready(result_ready), .busy(bz1));

  systolic_pe_acc #(.ROW(1), .COL(0), .DW(8), .AW(16), .K(2), .SIGNED(0)) u_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .out_a(oa2), .out_b(ob2), .out_valid(ov2), .result(res2), .result_valid(rv2),
    .result_ready(result_ready), .busy(bz2));

  typedef enum int {P_IDLE, P_ACC, P_DONE} phase_t;
  typedef struct {
    phase_t     phase;
    int         cnt;
    longint     acc;
    longint     res;
    bit         rv;
    logic [7:0] oa, ob;
    bit         ov;
  } mdl_t;

  mdl_t m[3];

  function automatic int k_of(int i);   return (i == 0) ? 4 : 2;  endfunction
  function automatic bit sg_of(int i);  return (i == 1);          endfunction
  function automatic int aw_of(int i);  return (i == 2) ? 16 : 24; endfunction

  function automatic longint norm(longint v, int aw, bit sgn);
    longint md = longint'(1) << aw;
`ifdef SYSTOLIC_PE_SAT_EN
    longint lo = sgn ? -(md / 2) : 0;
    longint hi = sgn ? (md / 2 - 1) : (md - 1);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
`else
    longint w = v % md;
    if (w < 0) w += md;
    if (sgn && (w >= md / 2)) w -= md;
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    longint p;
    bit     opened;
    if (rst) begin
      m[i].phase = P_IDLE; m[i].cnt = 0; m[i].acc = 0; m[i].res = 0;
      m[i].rv = 0; m[i].oa = 0; m[i].ob = 0; m[i].ov = 0;
      return;
    end
    m[i].ov = in_valid;
    if (in_valid) begin
      m[i].oa = in_a;
      m[i].ob = in_b;
    end
    opened = start && ((m[i].phase != P_DONE) || result_ready);
    if ((m[i].phase == P_DONE) && result_ready) begin
      m[i].rv    = 0;
      m[i].phase = P_IDLE;
    end
    if (opened) begin
      m[i].phase = P_ACC;
      m[i].cnt   = 0;
      m[i].acc   = 0;
    end
    if ((m[i].phase == P_ACC) && in_valid) begin
      p = sg_of(i) ? longint'($signed(in_a)) * longint'($signed(in_b))
                   : longint'(in_a) * longint'(in_b);
      m[i].acc = norm(m[i].acc + p, aw_of(i), sg_of(i));
      m[i].cnt++;
      if (m[i].cnt == k_of(i)) begin
        m[i].res   = m[i].acc;
        m[i].rv    = 1;
        m[i].phase = P_DONE;
      end
    end
  endtask

  task automatic compare(input int i);
    logic [63:0] mask = (64'd1 << aw_of(i)) - 64'd1;
    logic [63:0] r_obs;
    logic [7:0]  a_obs, b_obs;
    logic        v_obs, rv_obs, bz_obs;
    case (i)
      0:       begin r_obs = 64'(res0); a_obs = oa0; b_obs = ob0; v_obs = ov0; rv_obs = rv0; bz_obs = bz0; end
      1:       begin r_obs = 64'(res1); a_obs = oa1; b_obs = ob1; v_obs = ov1; rv_obs = rv1; bz_obs = bz1; end
      default: begin r_obs = 64'(res2); a_obs = oa2; b_obs = ob2; v_obs = ov2; rv_obs = rv2; bz_obs = bz2; end
    endcase
    check($sformatf("result[%0d]", i),       r_obs, 64'(m[i].res) & mask);
    check($sformatf("result_valid[%0d]", i), 64'(rv_obs), 64'(m[i].rv));
    check($sformatf("busy[%0d]", i),         64'(bz_obs), 64'(m[i].phase != P_IDLE));
    check($sformatf("out_valid[%0d]", i),    64'(v_obs), 64'(m[i].ov));
    check($sformatf("out_a[%0d]", i),        64'(a_obs), 64'(m[i].oa));
    check($sformatf("out_b[%0d]", i),        64'(b_obs), 64'(m[i].ob));
  endtask

  task automatic tick(input bit r, input bit s, input bit v,
                      input logic [7:0] a, input logic [7:0] b, input bit rdy);
    rst = r; start = s; in_valid = v; in_a = a; in_b = b; result_ready = rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      model_step(i);
      compare(i);
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input bit rdy);
    tick(1'b0, 1'b0, 1'b1, a, b, rdy);
  endtask

  task automatic drain();
    repeat (2) tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; result_ready = 1'b0;
    repeat (2) tick(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    check("reset_busy", 64'(bz0), 64'd0);
    check("reset_out_valid", 64'(ov0), 64'd0);

    // Basic tile: 1*5+2*6+3*7+4*8
    tick(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    op(8'd1, 8'd5, 1'b1); op(8'd2, 8'd6, 1'b1); op(8'd3, 8'd7, 1'b1); op(8'd4, 8'd8, 1'b1);
    check("basic_result", 64'(res0), 64'd70);
    check("basic_rv_set", 64'(rv0), 64'd1);
    tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check("basic_rv_one_cycle", 64'(rv0), 64'd0);
    drain();

    // Same tile with bubbles between operands
    tick(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    op(8'd1, 8'd5, 1'b1); tick(1'b0, 1'b0, 1'b0, 8'd9, 8'd9, 1'b1);
    op(8'd2, 8'd6, 1'b1); tick(1'b0, 1'b0, 1'b0, 8'd7, 8'd7, 1'b1);
    check("bubble_out_a_hold", 64'(oa0), 64'd2);
    op(8'd3, 8'd7, 1'b1); op(8'd4, 8'd8, 1'b1);
    check("bubble_result", 64'(res0), 64'd70);
    drain();

    // Signed K=2: -3*5 + 4*-2 = -23
    tick(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    op(8'hFD, 8'd5, 1'b1); op(8'd4, 8'hFE, 1'b1);
    check("signed_result", 64'(res1), 64'hFF_FFE9);
    drain();

    // Hold result while not accepted, then back-to-back tile
    tick(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    op(8'd1, 8'd5, 1'b0); op(8'd2, 8'd6, 1'b0); op(8'd3, 8'd7, 1'b0); op(8'd4, 8'd8, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, (c == 2), c[0], 8'd50, 8'd50, 1'b0);
      check("hold_result", 64'(res0), 64'd70);
      check("hold_busy", 64'(bz0), 64'd1);
    end
    tick(1'b0, 1'b1, 1'b1, 8'd2, 8'd3, 1'b1);
    check("b2b_released", 64'(rv0), 64'd0);
    check("b2b_busy", 64'(bz0), 64'd1);
    op(8'd1, 8'd1, 1'b1); op(8'd1, 8'd1, 1'b1); op(8'd1, 8'd1, 1'b1);
    check("b2b_result", 64'(res0), 64'd9);
    drain();

    // Restart after two operands, then reset mid-tile
    tick(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    op(8'd10, 8'd10, 1'b1); op(8'd10, 8'd10, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    op(8'd1, 8'd2, 1'b1); op(8'd1, 8'd2, 1'b1); op(8'd1, 8'd2, 1'b1); op(8'd1, 8'd2, 1'b1);
    check("restart_result", 64'(res0), 64'd8);
    drain();
    tick(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    op(8'd3, 8'd3, 1'b1); op(8'd3, 8'd3, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 8'd3, 8'd3, 1'b1);
    check("midreset_result", 64'(res0), 64'd0);
    check("midreset_out_a", 64'(oa0), 64'd0);
    check("midreset_busy", 64'(bz0), 64'd0);

    // AW=16 overflow: 255*255 twice
    tick(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    op(8'd255, 8'd255, 1'b1); op(8'd255, 8'd255, 1'b1);
`ifdef SYSTOLIC_PE_SAT_EN
    check("overflow_result", 64'(res2), 64'd65535);
`else
    check("overflow_result", 64'(res2), 64'd64514);
`endif
    drain();

    for (int c = 0; c < 1500; c++) begin
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
           8'($urandom), 8'($urandom), $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
